// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions used by the MEM-stage data-memory controller.
package mips_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned OPCODE_W   = 6;
    localparam int unsigned DMEM_CNT_W = 8;

    localparam logic [OPCODE_W-1:0] OP_LW = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW = 6'b101011;

    // Load data returned when the data memory never acknowledges
    localparam logic [XLEN-1:0] DMEM_ERR_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } dmem_state_t;

endpackage

// File: rtl/dmem_ack_timer.sv
// Ack-wait counter: clear on request issue, increment per unacknowledged cycle,
// registered terminal-count flag when the count reaches LIMIT-1.
module dmem_ack_timer
    import mips_pkg::*;
#(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic inc_i,
    output logic done_o
);

    localparam logic [DMEM_CNT_W-1:0] TERM = DMEM_CNT_W'(LIMIT - 1);
    localparam logic [DMEM_CNT_W-1:0] CMAX = '1;

    logic [DMEM_CNT_W-1:0] count_q;
    logic [DMEM_CNT_W-1:0] count_d;
    logic                  done_q;

    // Next count: clear wins, increment saturates at all-ones
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != CMAX)) begin
            count_d = count_q + DMEM_CNT_W'(1);
        end
    end

    // Count register and terminal-count flag derived from the next count
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            done_q  <= (count_d == TERM);
        end
    end

    assign done_o = done_q;

endmodule

// File: rtl/mem_stage_dmem_ctrl.sv
// MEM-stage data-memory controller: req/ack handshake to a variable-latency
// data memory, pipeline stall while outstanding, registered load data,
// misaligned-access and ack-timeout flagging.
module mem_stage_dmem_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned     ACK_TIMEOUT = 16,
    parameter logic [XLEN-1:0] ERR_DATA    = DMEM_ERR_DATA
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] mem_instr_in,
    input  logic            mem_valid_in,
    input  logic [XLEN-1:0] mem_alu_result_in,
    input  logic [XLEN-1:0] mem_GPR_rt_in,
    input  logic            wb_ena,
    output logic            mem_stall,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] mem_load_data,
    output logic            mem_load_valid,
    output logic            mem_misaligned,
    output logic            mem_bus_error
);

    dmem_state_t     state_q, state_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] ldata_q, ldata_d;
    logic            lvalid_q, lvalid_d;
    logic            mis_q, mis_d;
    logic            berr_q, berr_d;

    logic            stall_c;
    logic            tmr_clr_c;
    logic            tmr_inc_c;
    logic            tmr_done;

    logic [OPCODE_W-1:0] opcode;
    logic                is_lw;
    logic                is_sw;
    logic                mem_op;
    logic                aligned;
    logic                unused_instr;

    // Instruction decode for the op currently in MEM
    assign opcode       = mem_instr_in[XLEN-1 -: OPCODE_W];
    assign is_lw        = (opcode == OP_LW);
    assign is_sw        = (opcode == OP_SW);
    assign mem_op       = mem_valid_in && (is_lw || is_sw);
    assign aligned      = (mem_alu_result_in[1:0] == 2'b00);
    assign unused_instr = ^mem_instr_in[XLEN-OPCODE_W-1:0];

    // Ack wait counter
    dmem_ack_timer #(
        .LIMIT (ACK_TIMEOUT)
    ) u_ack_timer (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (tmr_clr_c),
        .inc_i  (tmr_inc_c),
        .done_o (tmr_done)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ldata_d   = ldata_q;
        lvalid_d  = lvalid_q;
        mis_d     = 1'b0;
        berr_d    = 1'b0;
        stall_c   = 1'b0;
        tmr_clr_c = 1'b0;
        tmr_inc_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    if (aligned) begin
                        stall_c   = 1'b1;
                        addr_d    = {mem_alu_result_in[XLEN-1:2], 2'b00};
                        wdata_d   = mem_GPR_rt_in;
                        we_d      = is_sw;
                        req_d     = 1'b1;
                        tmr_clr_c = 1'b1;
                        state_d   = ACCESS;
                    end else begin
                        mis_d    = 1'b1;
                        ldata_d  = '0;
                        lvalid_d = 1'b0;
                        state_d  = DONE;
                    end
                end
            end

            ACCESS: begin
                stall_c = 1'b1;
                if (dmem_ack) begin
                    req_d = 1'b0;
                    if (!we_q) begin
                        ldata_d  = dmem_rdata;
                        lvalid_d = 1'b1;
                    end
                    state_d = DONE;
                end else if (tmr_done) begin
                    req_d  = 1'b0;
                    berr_d = 1'b1;
                    if (!we_q) begin
                        ldata_d  = ERR_DATA;
                        lvalid_d = 1'b1;
                    end
                    state_d = DONE;
                end else begin
                    tmr_inc_c = 1'b1;
                end
            end

            DONE: begin
                // Same instruction stays in MEM until WB advances; never reissue
                if (wb_ena) begin
                    lvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ldata_q  <= '0;
            lvalid_q <= 1'b0;
            mis_q    <= 1'b0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ldata_q  <= ldata_d;
            lvalid_q <= lvalid_d;
            mis_q    <= mis_d;
            berr_q   <= berr_d;
        end
    end

    // Stall request is combinational but forced low while in reset
    assign mem_stall      = stall_c && !reset;
    assign dmem_req       = req_q;
    assign dmem_we        = we_q;
    assign dmem_addr      = addr_q;
    assign dmem_wdata     = wdata_q;
    assign mem_load_data  = ldata_q;
    assign mem_load_valid = lvalid_q;
    assign mem_misaligned = mis_q;
    assign mem_bus_error  = berr_q;

endmodule

// File: tb/tb_mem_stage_dmem_ctrl.sv
// Randomized self-checking bench for mem_stage_dmem_ctrl with an op-level
// reference model (stall/request cycle counts and result per transaction).
module tb_mem_stage_dmem_ctrl;

    localparam int unsigned T     = 4;
    localparam logic [31:0] ERR   = 32'hDEADBEEF;
    localparam logic [5:0]  OP_LW = 6'b100011;
    localparam logic [5:0]  OP_SW = 6'b101011;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_instr_in;
    logic        mem_valid_in;
    logic [31:0] mem_alu_result_in;
    logic [31:0] mem_GPR_rt_in;
    logic        wb_ena;
    logic        mem_stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] mem_load_data;
    logic        mem_load_valid;
    logic        mem_misaligned;
    logic        mem_bus_error;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_data = 32'h0;

    always #5 clk = ~clk;

    mem_stage_dmem_ctrl #(
        .ACK_TIMEOUT (T),
        .ERR_DATA    (ERR)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .mem_instr_in      (mem_instr_in),
        .mem_valid_in      (mem_valid_in),
        .mem_alu_result_in (mem_alu_result_in),
        .mem_GPR_rt_in     (mem_GPR_rt_in),
        .wb_ena            (wb_ena),
        .mem_stall         (mem_stall),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_wdata        (dmem_wdata),
        .dmem_ack          (dmem_ack),
        .dmem_rdata        (dmem_rdata),
        .mem_load_data     (mem_load_data),
        .mem_load_valid    (mem_load_valid),
        .mem_misaligned    (mem_misaligned),
        .mem_bus_error     (mem_bus_error)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One memory op through MEM; ack_after = ACCESS cycle index of the ack
    // (>= T means never), hold = DONE cycles with wb_ena low before release.
    task automatic run_op(input bit is_lw, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input int ack_after, input int hold);
        bit          aligned;
        bit          tmo;
        int          acc;
        int          stall_n;
        int          req_n;
        bit          stable_ok;
        logic [31:0] exp_data;
        aligned   = (addr[1:0] == 2'b00);
        tmo       = aligned && (ack_after >= int'(T));
        acc       = !aligned ? 0 : (tmo ? int'(T) : ack_after + 1);
        stall_n   = 0;
        req_n     = 0;
        stable_ok = 1'b1;
        if (!aligned)    exp_data = 32'h0;
        else if (!is_lw) exp_data = model_data;
        else if (tmo)    exp_data = ERR;
        else             exp_data = rd;
        model_data = exp_data;

        // IDLE cycle: op enters MEM
        @(posedge clk); #1;
        mem_instr_in      = {(is_lw ? OP_LW : OP_SW), 26'($urandom)};
        mem_valid_in      = 1'b1;
        mem_alu_result_in = addr;
        mem_GPR_rt_in     = wd;
        dmem_ack          = 1'($urandom);
        dmem_rdata        = $urandom;
        wb_ena            = 1'($urandom);
        #1;
        check("idle_valid", mem_load_valid, 0);
        check("idle_req", dmem_req, 0);
        stall_n += int'(mem_stall);

        // ACCESS cycles
        for (int k = 0; k < acc; k++) begin
            @(posedge clk); #1;
            dmem_ack   = (k == ack_after);
            dmem_rdata = (k == ack_after) ? rd : $urandom;
            wb_ena     = 1'($urandom);
            #1;
            stall_n += int'(mem_stall);
            req_n   += int'(dmem_req);
            if (dmem_addr !== addr || dmem_we !== !is_lw || dmem_wdata !== wd)
                stable_ok = 1'b0;
        end
        check("stall_cycles", stall_n, aligned ? acc + 1 : 0);
        check("req_cycles", req_n, acc);
        check("req_stable", stable_ok, 1);

        // First DONE cycle: stray ack must be ignored
        @(posedge clk); #1;
        dmem_ack   = 1'($urandom);
        dmem_rdata = $urandom;
        wb_ena     = (hold == 0);
        #1;
        check("done_stall", mem_stall, 0);
        check("done_req", dmem_req, 0);
        check("done_valid", mem_load_valid, is_lw && aligned);
        check("done_data", mem_load_data, exp_data);
        check("done_misaligned", mem_misaligned, !aligned);
        check("done_bus_error", mem_bus_error, tmo);

        // Held DONE cycles: nothing reissued, result held
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            dmem_ack   = 1'($urandom);
            dmem_rdata = $urandom;
            wb_ena     = (h == hold - 1);
            #1;
            check("hold_stall", mem_stall, 0);
            check("hold_req", dmem_req, 0);
            check("hold_valid", mem_load_valid, is_lw && aligned);
            check("hold_data", mem_load_data, exp_data);
            check("hold_misaligned", mem_misaligned, 0);
            check("hold_bus_error", mem_bus_error, 0);
        end
    endtask

    // One non-memory cycle (bubble or other opcode)
    task automatic run_nop();
        logic [5:0] op;
        @(posedge clk); #1;
        op = 6'($urandom);
        if ($urandom_range(0, 1) == 0) begin
            mem_valid_in = 1'b0;
            op           = OP_LW;
        end else begin
            mem_valid_in = 1'b1;
            if (op == OP_LW || op == OP_SW) op = 6'b000000;
        end
        mem_instr_in      = {op, 26'($urandom)};
        mem_alu_result_in = $urandom;
        dmem_ack          = 1'($urandom);
        wb_ena            = 1'($urandom);
        #1;
        check("nop_stall", mem_stall, 0);
        check("nop_req", dmem_req, 0);
    endtask

    initial begin
        logic [31:0] a;
        reset             = 1'b1;
        mem_instr_in      = {OP_LW, 26'h0};
        mem_valid_in      = 1'b1;
        mem_alu_result_in = 32'h0000_0100;
        mem_GPR_rt_in     = 32'h1111_2222;
        wb_ena            = 1'b0;
        dmem_ack          = 1'b0;
        dmem_rdata        = 32'h0;

        // Reset values, stall gated while in reset
        repeat (2) @(posedge clk);
        #2;
        check("rst_stall", mem_stall, 0);
        check("rst_req", dmem_req, 0);
        check("rst_we", dmem_we, 0);
        check("rst_addr", dmem_addr, 0);
        check("rst_wdata", dmem_wdata, 0);
        check("rst_ldata", mem_load_data, 0);
        check("rst_lvalid", mem_load_valid, 0);
        check("rst_mis", mem_misaligned, 0);
        check("rst_berr", mem_bus_error, 0);
        reset        = 1'b0;
        mem_valid_in = 1'b0;

        // Directed scenarios
        run_op(1'b1, 32'h0000_0100, 32'h0, 32'h1234_5678, 0, 0);
        run_op(1'b0, 32'h0000_0204, 32'hCAFE_F00D, 32'h0, 3, 0);
        run_op(1'b1, 32'h0000_0102, 32'h0, 32'h0, 0, 0);
        run_op(1'b1, 32'h0000_0400, 32'h0, 32'h5555_AAAA, 99, 1);
        run_op(1'b1, 32'h0000_0500, 32'h0, 32'h0BAD_F00D, 1, 3);
        run_op(1'b1, 32'h0000_0504, 32'h0, 32'h7777_8888, 0, 0);

        // Reset on the second ACCESS cycle
        @(posedge clk); #1;
        mem_instr_in      = {OP_LW, 26'h0};
        mem_valid_in      = 1'b1;
        mem_alu_result_in = 32'h0000_0300;
        dmem_ack          = 1'b0;
        wb_ena            = 1'b0;
        @(posedge clk); #2;
        check("rma_req_first", dmem_req, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("rma_stall_in_reset", mem_stall, 0);
        @(posedge clk); #1;
        reset        = 1'b0;
        mem_valid_in = 1'b0;
        dmem_ack     = 1'b1;
        dmem_rdata   = 32'hFFFF_0000;
        #1;
        check("rma_req", dmem_req, 0);
        check("rma_addr", dmem_addr, 0);
        check("rma_ldata", mem_load_data, 0);
        check("rma_lvalid", mem_load_valid, 0);
        check("rma_berr", mem_bus_error, 0);
        @(posedge clk); #2;
        check("rma_late_ack_req", dmem_req, 0);
        check("rma_late_ack_lvalid", mem_load_valid, 0);
        check("rma_late_ack_ldata", mem_load_data, 0);
        dmem_ack   = 1'b0;
        model_data = 32'h0;
        run_op(1'b1, 32'h0000_0600, 32'h0, 32'h600D_0600, 0, 0);

        // Randomized ops with occasional bubbles
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) run_nop();
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            run_op(1'($urandom), a, $urandom, $urandom,
                   int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
        end

        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
